// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master: FSM state encoding and
// the four clock modes packed as {cpol, cpha}.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    GAP
  } spi_state_e;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer for the SPI master: down-counter that ticks once every
// i_div+1 cycles while enabled and restarts from i_div when enable rises.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] cnt;
  logic             en_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt  <= '0;
      en_d <= 1'b0;
    end else begin
      en_d <= i_en;
      if (i_en && !en_d) begin
        cnt <= i_div;
      end else if (i_en) begin
        cnt <= (cnt == '0) ? i_div : cnt - 1'b1;
      end
    end
  end

  // en_d gates the tick so the first window after a restart is a full H cycles
  assign o_tick = en_d && (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transfer engine: programmable SCK divider, CPOL/CPHA modes,
// MSB/LSB-first frames and decoded chip selects behind a start/busy/done handshake.
//
// state | meaning
// IDLE  | CS high, SCK follows i_cpol, waiting for i_start
// LEAD  | CS low, first MOSI bit set up for one half-period
// XFER  | 2*DATA_W SCK edges, one per half-period tick
// TRAIL | SCK back at CPOL, CS still low for one half-period
// GAP   | CS high, done pulse on entry, busy held for one half-period
module spi_master_ctrl #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 4,
  parameter int DIV_W  = 8,
  parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CS_W-1:0]   i_cs_sel,
  input  logic              i_cpol,
  input  logic              i_cpha,
  input  logic              i_lsb_first,
  input  logic [DIV_W-1:0]  i_div,
  input  logic              i_miso,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_data,
  output logic              o_sck,
  output logic              o_mosi,
  output logic [NUM_CS-1:0] o_cs_n
);

  import spi_pkg::*;

  localparam int EDGES = 2 * DATA_W;
  localparam int EC_W  = $clog2(2 * DATA_W + 1);

  spi_state_e state, nxt;

  logic              tick, accept, do_edge, enter_gap;
  logic              leading, last_edge, sample, shift_tx;
  logic [EC_W-1:0]   edge_cnt, edge_num;
  logic [EC_W-2:0]   tx_idx;
  logic [DATA_W-1:0] data_q, rx_q, tx_lsb, tx_msb;
  logic              cpol_q, cpha_q, lsb_q;
  logic [DIV_W-1:0]  div_q, div_src;
  logic              div_en;

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    cs_decode = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) cs_decode[i] = 1'b0;
    end
  endfunction

  // The divider sees i_div directly in the accept cycle, the latched copy afterwards
  assign div_en  = (nxt != IDLE);
  assign div_src = (state == IDLE) ? i_div : div_q;

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (div_en),
    .i_div  (div_src),
    .o_tick (tick)
  );

  assign edge_num  = edge_cnt + 1'b1;
  assign leading   = edge_num[0];
  assign last_edge = (edge_cnt == EC_W'(EDGES - 1));
  assign tx_idx    = edge_num[EC_W-1:1];
  assign tx_lsb    = data_q >> tx_idx;
  assign tx_msb    = data_q << tx_idx;
  assign sample    = do_edge && (leading ^ cpha_q);
  assign shift_tx  = do_edge && (cpha_q ? leading : (!leading && !last_edge));
  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt       = state;
    accept    = 1'b0;
    do_edge   = 1'b0;
    enter_gap = 1'b0;
    case (state)
      IDLE: if (i_start) begin
        accept = 1'b1;
        nxt    = LEAD;
      end
      LEAD: if (tick) begin
        do_edge = 1'b1;
        nxt     = XFER;
      end
      XFER: if (tick) begin
        do_edge = 1'b1;
        if (last_edge) nxt = TRAIL;
      end
      TRAIL: if (tick) begin
        enter_gap = 1'b1;
        nxt       = GAP;
      end
      GAP: if (tick) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_done   <= 1'b0;
      o_data   <= '0;
      o_sck    <= 1'b0;
      o_mosi   <= 1'b0;
      o_cs_n   <= '1;
      data_q   <= '0;
      rx_q     <= '0;
      edge_cnt <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      lsb_q    <= 1'b0;
      div_q    <= '0;
    end else begin
      o_done <= enter_gap;
      if (state == IDLE) begin
        o_sck <= i_cpol;
        if (accept) begin
          data_q   <= i_data;
          cpol_q   <= i_cpol;
          cpha_q   <= i_cpha;
          lsb_q    <= i_lsb_first;
          div_q    <= i_div;
          o_cs_n   <= cs_decode(i_cs_sel);
          o_mosi   <= i_lsb_first ? i_data[0] : i_data[DATA_W-1];
          edge_cnt <= '0;
          rx_q     <= '0;
        end else begin
          o_cs_n <= '1;
          o_mosi <= 1'b0;
        end
      end
      if (do_edge) begin
        o_sck    <= ~o_sck;
        edge_cnt <= edge_num;
      end
      if (sample) begin
        rx_q <= lsb_q ? {i_miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], i_miso};
      end
      if (shift_tx) begin
        o_mosi <= lsb_q ? tx_lsb[0] : tx_msb[DATA_W-1];
      end
      if (enter_gap) begin
        o_cs_n <= '1;
        o_data <= rx_q;
        o_sck  <= cpol_q;
      end
    end
  end

endmodule
